pc_sequencer: RTL and testbench

- Control block for the extended program counter: every cycle it decides whether the PC advances, holds, or redirects, and drives the PC source selects.
- Inputs come from the decode stage (opcode, funct, ALU zero), the hazard unit (stall) and instruction memory (ready).
- Outputs feed the PC branch/jump/jump-register muxes, the PC write enable and the IF/ID flush.
- Adds memory-wait timeout supervision and a halt state on syscall.

---
 rtl/pc_sequencer_pkg.sv | 35 +++
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_redirect_decode.sv | 36 +++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module   : pc_sequencer_pkg
// Brief    : Shared opcode/funct constants and state encoding for the PC
//            sequencer and its redirect decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    // Decode-stage opcode / funct values
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    // Sequencer state encoding
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    typedef enum logic [1:0] {
        RUN      = ST_RUN,
        WAIT_MEM = ST_WAIT_MEM,
        FLUSH    = ST_FLUSH,
        HALT     = ST_HALT
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Decode/hazard/imem inputs and PC-mux control outputs of the
//            PC sequencer. master = surrounding pipeline, slave = sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       stall_req;
    logic       imem_ready;
    logic       select_branch;
    logic       select_jump;
    logic       select_jump_r;
    logic       pc_write;
    logic       if_flush;
    logic       halted;
    logic       timeout_err;

    modport master (
        output opcode, funct, zero, stall_req, imem_ready,
        input  select_branch, select_jump, select_jump_r,
               pc_write, if_flush, halted, timeout_err
    );

    modport slave (
        input  opcode, funct, zero, stall_req, imem_ready,
        output select_branch, select_jump, select_jump_r,
               pc_write, if_flush, halted, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/pc_redirect_decode.sv
// ============================================================================
// Module   : pc_redirect_decode
// Brief    : Combinational classification of the decode-stage instruction
//            into taken branch / jump / jump-register / syscall. The opcode
//            compares are mutually exclusive, so at most one flag is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_decode
    import pc_sequencer_pkg::*;
(
    input  wire logic [5:0] opcode,
    input  wire logic [5:0] funct,
    input  wire logic       zero,
    output logic            taken_branch,
    output logic            take_jump,
    output logic            take_jump_r,
    output logic            is_syscall
);

    logic w_rtype;

    // Instruction class flags straight from opcode/funct/zero
    always_comb begin
        w_rtype      = (opcode == OP_RTYPE);
        taken_branch = ((opcode == OP_BEQ) &&  zero) ||
                       ((opcode == OP_BNE) && !zero);
        take_jump    = (opcode == OP_J) || (opcode == OP_JAL);
        take_jump_r  = w_rtype && (funct == FN_JR);
        is_syscall   = w_rtype && (funct == FN_SYSCALL);
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : PC control FSM (RUN / WAIT_MEM / FLUSH / HALT). Drives the PC
//            source selects (Mealy), PC write enable, IF/ID flush, halt
//            status and a sticky instruction-memory timeout flag.
// Config   : PC_DELAY_SLOT_EN - branch-delay-slot mode; taken redirects stay
//            in RUN and if_flush is never asserted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    pc_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             terr_q, terr_d;

    logic taken_branch, take_jump, take_jump_r, is_syscall;
    logic sel_branch, sel_jump, sel_jump_r, pc_wr, flush;

    pc_redirect_decode u_decode (
        .opcode       (bus.opcode),
        .funct        (bus.funct),
        .zero         (bus.zero),
        .taken_branch (taken_branch),
        .take_jump    (take_jump),
        .take_jump_r  (take_jump_r),
        .is_syscall   (is_syscall)
    );

    // Wait counter increment that sticks at all-ones instead of wrapping
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state and Mealy outputs; everything held at 0 in a reset cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        sel_branch = 1'b0;
        sel_jump   = 1'b0;
        sel_jump_r = 1'b0;
        pc_wr      = 1'b0;
        flush      = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (is_syscall) begin
                        state_d = HALT;
                    end else if (bus.stall_req) begin
                        // hold: a pending redirect waits for stall to drop
                        state_d = RUN;
                    end else if (!bus.imem_ready) begin
                        state_d = WAIT_MEM;
                        cnt_d   = CNT_W'(1);
                    end else if (taken_branch || take_jump || take_jump_r) begin
                        sel_branch = taken_branch;
                        sel_jump   = take_jump;
                        sel_jump_r = take_jump_r;
                        pc_wr      = 1'b1;
`ifdef PC_DELAY_SLOT_EN
                        state_d    = RUN;
`else
                        state_d    = FLUSH;
`endif
                    end else begin
                        pc_wr = 1'b1;
                    end
                end
                WAIT_MEM: begin
                    if (bus.imem_ready) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_LIMIT) begin
                            terr_d  = 1'b1;
                            state_d = HALT;
                        end
                    end
                end
                FLUSH: begin
`ifndef PC_DELAY_SLOT_EN
                    flush = 1'b1;
`endif
                    pc_wr = bus.imem_ready;
                    if (bus.imem_ready) begin
                        state_d = RUN;
                    end else begin
                        state_d = WAIT_MEM;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign bus.select_branch = sel_branch;
    assign bus.select_jump   = sel_jump;
    assign bus.select_jump_r = sel_jump_r;
    assign bus.pc_write      = pc_wr;
    assign bus.if_flush      = flush;
    assign bus.halted        = (state_q == HALT) && !reset;
    assign bus.timeout_err   = terr_q && !reset;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Vector-table bench for pc_sequencer. Each record gives one
//            cycle of inputs and the expected outputs
//            {sel_branch, sel_jump, sel_jump_r, pc_write, if_flush, halted,
//            timeout_err}; expectations queue on drive and are checked at
//            the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_sequencer;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 8;
`ifdef PC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] F_JR = 6'b001000;
    localparam logic [5:0] F_SC = 6'b001100;

    // expected output patterns
    localparam logic [6:0] E_IDLE = 7'b000_0_0_0_0;
    localparam logic [6:0] E_SEQ  = 7'b000_1_0_0_0;
    localparam logic [6:0] E_BR   = 7'b100_1_0_0_0;
    localparam logic [6:0] E_J    = 7'b010_1_0_0_0;
    localparam logic [6:0] E_JR   = 7'b001_1_0_0_0;
    localparam logic [6:0] E_HALT = 7'b000_0_0_1_0;
    localparam logic [6:0] E_TOUT = 7'b000_0_0_1_1;
    // cycle after a taken redirect with imem ready and a NOP in decode
    localparam logic [6:0] E_FL   = DS ? 7'b000_1_0_0_0 : 7'b000_1_1_0_0;
    // same cycle but imem not ready
    localparam logic [6:0] E_FL0  = DS ? 7'b000_0_0_0_0 : 7'b000_0_1_0_0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       st;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(string nm, logic r, logic [5:0] op, logic [5:0] fn,
                                logic z, logic st, logic rdy, logic [6:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = op; v.fn = fn;
        v.z = z; v.st = st; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic void nop(string nm, logic rdy, logic [6:0] e);
        add(nm, 1'b0, NOP, NOP, 1'b0, 1'b0, rdy, e);
    endfunction

    function automatic void rst_cycle(string nm);
        add(nm, 1'b1, BEQ, NOP, 1'b1, 1'b0, 1'b0, E_IDLE);
    endfunction

    task automatic check();
        sb_t        s;
        logic [6:0] obs;
        obs = {bus.select_branch, bus.select_jump, bus.select_jump_r,
               bus.pc_write, bus.if_flush, bus.halted, bus.timeout_err};
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %b want <queued entry>", obs);
        end else begin
            s = sb.pop_front();
            if (obs !== s.exp) begin
                n_bad++;
                $display("FAIL %s: got %b want %b (br j jr pcw flush halt terr)",
                         s.name, obs, s.exp);
            end
        end
    endtask

    initial begin
        bus.opcode = NOP; bus.funct = NOP; bus.zero = 1'b0;
        bus.stall_req = 1'b0; bus.imem_ready = 1'b0;

        // reset with a live beq on the bus: outputs must stay 0
        rst_cycle("reset0");
        rst_cycle("reset1");
        for (int i = 0; i < 5; i++) nop($sformatf("seq%0d", i), 1'b1, E_SEQ);

        // beq taken, then bubble
        add("beq_taken", 1'b0, BEQ, NOP, 1'b1, 1'b0, 1'b1, E_BR);
        nop("beq_flush", 1'b1, E_FL);
        nop("beq_after", 1'b1, E_SEQ);
        // bne with zero=1 is not taken; no flush after
        add("bne_nt", 1'b0, BNE, NOP, 1'b1, 1'b0, 1'b1, E_SEQ);
        nop("bne_noflush", 1'b1, E_SEQ);
        add("beq_nt", 1'b0, BEQ, NOP, 1'b0, 1'b0, 1'b1, E_SEQ);
        add("bne_taken", 1'b0, BNE, NOP, 1'b0, 1'b0, 1'b1, E_BR);
        nop("bne_flush", 1'b1, E_FL);
        add("jal", 1'b0, JAL, NOP, 1'b0, 1'b0, 1'b1, E_J);
        nop("jal_flush", 1'b1, E_FL);

        // jr held by stall for 3 cycles, taken when stall drops
        for (int i = 0; i < 3; i++)
            add($sformatf("jr_stall%0d", i), 1'b0, NOP, F_JR, 1'b0, 1'b1, 1'b1, E_IDLE);
        add("jr_go", 1'b0, NOP, F_JR, 1'b0, 1'b0, 1'b1, E_JR);
        nop("jr_flush", 1'b1, E_FL);

        // j followed by a not-ready flush cycle, then memory returns
        add("j_go", 1'b0, JMP, NOP, 1'b0, 1'b0, 1'b1, E_J);
        nop("j_flush_nr", 1'b0, E_FL0);
        nop("j_wait_rdy", 1'b1, E_IDLE);
        nop("j_resume", 1'b1, E_SEQ);

        // stall beats not-ready: stays in RUN, so next ready cycle writes PC
        nop("stall_nr", 1'b0, E_IDLE);
        bus.stall_req = 1'b0;
        vecs[vecs.size()-1].st = 1'b1;
        nop("stall_nr_after", 1'b1, E_SEQ);

        // 5 cycles not ready, decode ignored in WAIT_MEM, stall ignored too
        nop("w5_enter", 1'b0, E_IDLE);
        for (int i = 1; i < 5; i++)
            add($sformatf("w5_wait%0d", i), 1'b0, BEQ, NOP, 1'b1, 1'b0, 1'b0, E_IDLE);
        add("w5_ready", 1'b0, BEQ, NOP, 1'b1, 1'b1, 1'b1, E_IDLE);
        nop("w5_resume", 1'b1, E_SEQ);

        // boundary: MEM_TIMEOUT-1 low cycles does not time out
        for (int i = 0; i < MEM_TIMEOUT - 1; i++)
            nop($sformatf("w15_low%0d", i), 1'b0, E_IDLE);
        nop("w15_ready", 1'b1, E_IDLE);
        nop("w15_resume", 1'b1, E_SEQ);

        // reset in the middle of WAIT_MEM
        nop("rw_enter", 1'b0, E_IDLE);
        nop("rw_wait", 1'b0, E_IDLE);
        rst_cycle("rw_reset");
        nop("rw_run", 1'b1, E_SEQ);

        // reset in the middle of FLUSH: no flush afterwards
        add("rf_beq", 1'b0, BEQ, NOP, 1'b1, 1'b0, 1'b1, E_BR);
        rst_cycle("rf_reset");
        nop("rf_run", 1'b1, E_SEQ);

        // MEM_TIMEOUT low cycles -> halted with timeout_err
        for (int i = 0; i < MEM_TIMEOUT; i++)
            nop($sformatf("to_low%0d", i), 1'b0, E_IDLE);
        nop("to_halt", 1'b1, E_TOUT);
        add("to_halt_jr", 1'b0, NOP, F_JR, 1'b0, 1'b0, 1'b1, E_TOUT);
        rst_cycle("to_reset");
        nop("to_cleared", 1'b1, E_SEQ);

        // syscall halts even with stall and not-ready; held 10 cycles
        add("sc", 1'b0, NOP, F_SC, 1'b0, 1'b1, 1'b0, E_IDLE);
        for (int i = 0; i < 10; i++)
            add($sformatf("sc_halt%0d", i), 1'b0, BEQ, NOP, 1'b1, 1'b0, 1'b1, E_HALT);
        rst_cycle("sc_reset");
        nop("sc_run", 1'b1, E_SEQ);

        foreach (vecs[i]) begin
            sb_t s;
            @(posedge clk);
            #1;
            reset          = vecs[i].rst;
            bus.opcode     = vecs[i].op;
            bus.funct      = vecs[i].fn;
            bus.zero       = vecs[i].z;
            bus.stall_req  = vecs[i].st;
            bus.imem_ready = vecs[i].rdy;
            s.name = vecs[i].name;
            s.exp  = vecs[i].exp;
            sb.push_back(s);
            @(negedge clk);
            check();
        end

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
